// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the multi-cycle CPU: opcodes, functs, ALU codes,
// operand-source codes, pc_source codes and control-FSM state encodings.
// Latency: n/a (declarations only). Backpressure: n/a.
// The ALU wrapper imports the same ALU_* codes so both sides agree on alu_ctl.
package cpu_ctrl_pkg;

  localparam int CTRL_ST_W   = 4;
  localparam int CTRL_ACTL_W = 4;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU control codes
  localparam logic [CTRL_ACTL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_ACTL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_ACTL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_ACTL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTRL_ACTL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [CTRL_ACTL_W-1:0] ALU_NOR = 4'b1100;

  // ALU operand sources
  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_REG     = 1'b1;
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // Control FSM state encodings; 13..15 are unused and recover to FETCH.
  localparam logic [CTRL_ST_W-1:0] S_FETCH    = 4'd0;
  localparam logic [CTRL_ST_W-1:0] S_DECODE   = 4'd1;
  localparam logic [CTRL_ST_W-1:0] S_MEM_ADDR = 4'd2;
  localparam logic [CTRL_ST_W-1:0] S_MEM_RD   = 4'd3;
  localparam logic [CTRL_ST_W-1:0] S_MEM_WB   = 4'd4;
  localparam logic [CTRL_ST_W-1:0] S_MEM_WR   = 4'd5;
  localparam logic [CTRL_ST_W-1:0] S_R_EXEC   = 4'd6;
  localparam logic [CTRL_ST_W-1:0] S_R_WB     = 4'd7;
  localparam logic [CTRL_ST_W-1:0] S_I_EXEC   = 4'd8;
  localparam logic [CTRL_ST_W-1:0] S_I_WB     = 4'd9;
  localparam logic [CTRL_ST_W-1:0] S_BRANCH   = 4'd10;
  localparam logic [CTRL_ST_W-1:0] S_JUMP     = 4'd11;
  localparam logic [CTRL_ST_W-1:0] S_HALT     = 4'd12;

  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/alu_ctl_dec.sv
// ALU control decoder: maps opcode/funct to alu_ctl and immediate-extension select.
// Latency: purely combinational. Backpressure: none.
// Ports: opcode, funct in; alu_ctl (ALU operation), off (1 = zero-extend immediate) out.
module alu_ctl_dec
  import cpu_ctrl_pkg::*;
#(
  parameter int ACTL_W = CTRL_ACTL_W
) (
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  output logic [ACTL_W-1:0] alu_ctl,
  output logic              off
);

  always_comb begin
    alu_ctl = ALU_ADD;
    off     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_ctl = ALU_ADD;
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_NOR:  alu_ctl = ALU_NOR;
          FN_SLT:  alu_ctl = ALU_SLT;
          default: alu_ctl = ALU_ADD; // unsupported funct executes as ADD
        endcase
      end
      OP_ADDI: alu_ctl = ALU_ADD;
      OP_SLTI: alu_ctl = ALU_SLT;
      // Logical immediates take the zero-extended form of the immediate.
      OP_ANDI: begin
        alu_ctl = ALU_AND;
        off     = 1'b1;
      end
      OP_ORI: begin
        alu_ctl = ALU_OR;
        off     = 1'b1;
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_ctrl_fsm.sv
// Multi-cycle CPU control FSM: decodes opcode/funct and drives datapath enables and ALU selects.
// Latency: Moore outputs valid every cycle from the registered state; lw 5, sw/R/I 4, beq/bne/j 3 cycles.
// Backpressure: none; the FSM advances every clock and never stalls.
// Ports: clk, rst (sync, active-high); opcode/funct from IR; pc_write, pc_write_cond, branch_ne,
//   pc_source, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
//   alu_src_b, off, ls, alu_ctl, instr_done, illegal.
// Build option CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap into HALT (illegal=1 until rst);
//   when undefined, unknown opcodes retire as a 2-cycle NOP and illegal is tied low.
module multi_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int ST_W   = CTRL_ST_W,
  parameter int ACTL_W = CTRL_ACTL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic              branch_ne,
  output logic [1:0]        pc_source,
  output logic              iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic              off,
  output logic              ls,
  output logic [ACTL_W-1:0] alu_ctl,
  output logic              instr_done,
  output logic              illegal
);

  logic [ST_W-1:0]   state;
  logic [ST_W-1:0]   state_next;
  logic [ACTL_W-1:0] dec_alu_ctl;
  logic              dec_off;

  alu_ctl_dec #(.ACTL_W(ACTL_W)) u_alu_ctl_dec (
    .opcode  (opcode),
    .funct   (funct),
    .alu_ctl (dec_alu_ctl),
    .off     (dec_off)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) state_next = S_MEM_ADDR;
        else if (opcode == OP_RTYPE)                state_next = S_R_EXEC;
        else if (is_itype(opcode))                  state_next = S_I_EXEC;
        else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) state_next = S_BRANCH;
        else if (opcode == OP_J)                    state_next = S_JUMP;
        else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_next = S_HALT;
`else
          state_next = S_FETCH;
`endif
        end
      end
      // Anything that is not lw here must be sw, since only those two reach MEM_ADDR.
      S_MEM_ADDR: state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_next = S_MEM_WB;
      S_R_EXEC:   state_next = S_R_WB;
      S_I_EXEC:   state_next = S_I_WB;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT:     state_next = S_HALT;
`endif
      // Last-state-of-instruction states and unused encodings all return to FETCH.
      default:    state_next = S_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = PCS_ALU;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_REG;
    off           = 1'b0;
    ls            = 1'b0;
    alu_ctl       = ALU_ADD;
    instr_done    = 1'b0;
    illegal       = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
      end
      // Speculatively compute the branch target into ALUOut.
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        ls        = 1'b1;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        alu_ctl   = dec_alu_ctl;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_ctl   = dec_alu_ctl;
        off       = dec_off;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = SRCA_REG;
        alu_src_b     = SRCB_REG;
        alu_ctl       = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
        branch_ne     = (opcode == OP_BNE);
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCS_JUMP;
        instr_done = 1'b1;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT: illegal = 1'b1;
`endif
      default: ;
    endcase

    // Reset dominates: nothing, including alu_ctl, is driven while rst is high.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      pc_source     = 2'b00;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      off           = 1'b0;
      ls            = 1'b0;
      alu_ctl       = '0;
      instr_done    = 1'b0;
      illegal       = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_ctrl_fsm.sv
// Self-checking bench for multi_ctrl_fsm: directed instructions, reset cases and random instruction mix
// compared cycle by cycle against an instruction-level expected-output table.
module tb_multi_ctrl_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       off;
    logic       ls;
    logic [3:0] alu_ctl;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, off, ls, instr_done, illegal;
  logic [1:0] pc_source, alu_src_b;
  logic [3:0] alu_ctl;

  always #5 clk = ~clk;

  multi_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_source(pc_source), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .off(off), .ls(ls), .alu_ctl(alu_ctl),
    .instr_done(instr_done), .illegal(illegal)
  );

  ctl_t obs;
  always_comb begin
    obs.pc_write = pc_write;   obs.pc_write_cond = pc_write_cond; obs.branch_ne = branch_ne;
    obs.pc_source = pc_source; obs.iord = iord;   obs.mem_read = mem_read;
    obs.mem_write = mem_write; obs.ir_write = ir_write; obs.reg_dst = reg_dst;
    obs.mem_to_reg = mem_to_reg; obs.reg_write = reg_write; obs.alu_src_a = alu_src_a;
    obs.alu_src_b = alu_src_b; obs.off = off; obs.ls = ls; obs.alu_ctl = alu_ctl;
    obs.instr_done = instr_done; obs.illegal = illegal;
  end

  int   vectors = 0;
  int   miscompares = 0;
  ctl_t exp_v [0:7];
  int   exp_n;

  logic [5:0] legal_ops [0:9] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
  logic [5:0] r_functs  [0:6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};

  // Idle control word: everything off, ALU defaults to ADD.
  function automatic ctl_t idle();
    ctl_t c = '0;
    c.alu_ctl = 4'b0010;
    return c;
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return 4'b0010;
      6'h22: return 4'b0110;
      6'h24: return 4'b0000;
      6'h25: return 4'b0001;
      6'h27: return 4'b1100;
      6'h2A: return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  // Build the expected per-cycle control words for one instruction, from FETCH to its last cycle.
  task automatic build(input logic [5:0] op, input logic [5:0] fn);
    ctl_t c;
    c = idle(); c.mem_read = 1; c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 2'b01;
    exp_v[0] = c;
    c = idle(); c.alu_src_b = 2'b11;
    exp_v[1] = c;
    exp_n = 2;
    if (op == 6'h23 || op == 6'h2B) begin
      c = idle(); c.alu_src_a = 1; c.alu_src_b = 2'b10; c.ls = 1;
      exp_v[2] = c;
      if (op == 6'h23) begin
        c = idle(); c.mem_read = 1; c.iord = 1;                        exp_v[3] = c;
        c = idle(); c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; exp_v[4] = c;
        exp_n = 5;
      end else begin
        c = idle(); c.mem_write = 1; c.iord = 1; c.instr_done = 1;     exp_v[3] = c;
        exp_n = 4;
      end
    end else if (op == 6'h00) begin
      c = idle(); c.alu_src_a = 1; c.alu_ctl = r_alu(fn);              exp_v[2] = c;
      c = idle(); c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1;    exp_v[3] = c;
      exp_n = 4;
    end else if (op == 6'h08 || op == 6'h0A || op == 6'h0C || op == 6'h0D) begin
      c = idle(); c.alu_src_a = 1; c.alu_src_b = 2'b10;
      if (op == 6'h0A) c.alu_ctl = 4'b0111;
      if (op == 6'h0C) begin c.alu_ctl = 4'b0000; c.off = 1; end
      if (op == 6'h0D) begin c.alu_ctl = 4'b0001; c.off = 1; end
      exp_v[2] = c;
      c = idle(); c.reg_write = 1; c.instr_done = 1;                   exp_v[3] = c;
      exp_n = 4;
    end else if (op == 6'h04 || op == 6'h05) begin
      c = idle(); c.alu_src_a = 1; c.alu_ctl = 4'b0110; c.pc_write_cond = 1;
      c.pc_source = 2'b01; c.branch_ne = (op == 6'h05); c.instr_done = 1;
      exp_v[2] = c;
      exp_n = 3;
    end else if (op == 6'h02) begin
      c = idle(); c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1;
      exp_v[2] = c;
      exp_n = 3;
    end
  endtask

  task automatic check(input string tag, input ctl_t e);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // Entered and left just after a rising edge with the DUT in FETCH.
  // Opcode/funct are garbage during FETCH since the DUT must ignore them there.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input string tag);
    build(op, fn);
    for (int i = 0; i < exp_n; i++) begin
      opcode = (i == 0) ? 6'($urandom_range(0, 63)) : op;
      funct  = (i == 0) ? 6'($urandom_range(0, 63)) : fn;
      @(negedge clk);
      check($sformatf("%s op=%h fn=%h cyc%0d", tag, op, fn, i + 1), exp_v[i]);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    ctl_t zero_v;
    logic [5:0] op, fn;
    zero_v = '0;
    rst = 1'b1; opcode = 6'h3F; funct = 6'h3F;

    // Reset held for 3 cycles: all outputs low.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("reset_cyc%0d", i + 1), zero_v);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    run(6'h23, 6'h00, "lw");
    run(6'h2B, 6'h11, "sw");
    foreach (r_functs[k]) run(6'h00, r_functs[k], "rtype");
    run(6'h00, 6'h3B, "rtype_unk");
    run(6'h05, 6'h00, "bne");
    run(6'h04, 6'h00, "beq");
    run(6'h02, 6'h00, "j");
    run(6'h0D, 6'h00, "ori");
    run(6'h08, 6'h00, "addi");
    run(6'h0A, 6'h00, "slti");
    run(6'h0C, 6'h00, "andi");

    // ori interrupted by reset in I_EXEC: outputs (incl. reg_write) stay low, then a clean restart.
    build(6'h0D, 6'h00);
    for (int i = 0; i < 2; i++) begin
      opcode = 6'h0D; funct = 6'h00;
      @(negedge clk);
      check($sformatf("ori_rst cyc%0d", i + 1), exp_v[i]);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk); check("ori_rst in_iexec", zero_v);
    @(posedge clk); #1;
    @(negedge clk); check("ori_rst held", zero_v);
    @(posedge clk); #1;
    rst = 1'b0;
    run(6'h2B, 6'h00, "after_rst_sw");

    // Unknown opcode 0x3F.
    run(6'h3F, 6'h00, "illegal");
`ifdef CTRL_ILLEGAL_TRAP_EN
    begin
      ctl_t h;
      h = idle(); h.illegal = 1'b1;
      for (int i = 0; i < 10; i++) begin
        opcode = 6'($urandom_range(0, 63));
        @(negedge clk); check($sformatf("halt_cyc%0d", i + 1), h);
        @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
`endif
    run(6'h23, 6'h00, "after_illegal_lw");

    // Random instruction mix.
    for (int n = 0; n < 150; n++) begin
      op = legal_ops[$urandom_range(0, 9)];
`ifndef CTRL_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
`endif
      fn = ($urandom_range(0, 1) == 0) ? r_functs[$urandom_range(0, 6)] : 6'($urandom_range(0, 63));
      run(op, fn, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_ctrl_fsm.md
Name: multi_ctrl_fsm

Overview:
Control-unit FSM for the multi-cycle CPU. It sits directly upstream of the ALU wrapper. It decodes the latched instruction's opcode/funct and, every cycle, drives the ALU operand selects (A/B source, offset select, load/store flag, 4-bit ALU control) plus all datapath enables. The datapath registers (IR, A, B, ALUOut, MDR, PC) live outside this block.

Parameters:
ST_W, 4, state register width
ACTL_W, 4, ALU control width (matches ALU wrapper alu_ctl)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if branch taken (datapath ANDs with zero/~zero)
branch_ne  out  1  1 = bne (take on ~zero), 0 = beq
iord  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_dst  out  1  write register: 0 = rt, 1 = rd
mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
reg_write  out  1  register-file write
alu_src_a  out  1  0 = PC, 1 = A register
alu_src_b  out  2  00 = B, 01 = constant 4, 10 = imm ext, 11 = imm ext << 2
off  out  1  imm extension: 0 = sign, 1 = zero (andi/ori)
ls  out  1  ALU computing a load/store address
alu_ctl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
instr_done  out  1  1-cycle pulse in the last state of each instruction
illegal  out  1  sticky illegal-opcode flag (feature only)

Behaviour:
- Moore machine: the state is registered and outputs decode from the state plus opcode/funct.
- rst high at a clk edge sets state to FETCH. While rst is high, every output is forced to 0. The first FETCH actions occur in the cycle after rst deasserts. Reset mid-instruction abandons it with no memory or register write.
- States and actions:
  - FETCH: mem_read, ir_write, pc_write, iord=0, src_a=0, src_b=01, ADD. Next state DECODE.
  - DECODE: src_a=0, src_b=11, off=0, ADD (branch target into ALUOut). Next state by opcode:
    - lw 0x23 / sw 0x2B -> MEM_ADDR
    - R-type 0x00 -> R_EXEC
    - addi 0x08 / slti 0x0A / andi 0x0C / ori 0x0D -> I_EXEC
    - beq 0x04 / bne 0x05 -> BRANCH
    - j 0x02 -> JUMP
    - other -> FETCH
  - MEM_ADDR: src_a=1, src_b=10, off=0, ls=1, ADD. Next state MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: mem_read, iord=1. Next state MEM_WB.
  - MEM_WB: reg_write, mem_to_reg=1, reg_dst=0, instr_done. Next state FETCH.
  - MEM_WR: mem_write, iord=1, instr_done. Next state FETCH.
  - R_EXEC: src_a=1, src_b=00, alu_ctl from funct:
    - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT
    - any other funct gives ADD
    - Next state R_WB.
  - R_WB: reg_write, reg_dst=1, mem_to_reg=0, instr_done. Next state FETCH.
  - I_EXEC: src_a=1, src_b=10.
    - addi: ADD, off=0
    - slti: SLT, off=0
    - andi: AND, off=1
    - ori: OR, off=1
    - Next state I_WB.
  - I_WB: reg_write, reg_dst=0, mem_to_reg=0, instr_done. Next state FETCH.
  - BRANCH: src_a=1, src_b=00, SUB, pc_write_cond, pc_source=01, branch_ne=(opcode==0x05), instr_done. Next state FETCH.
  - JUMP: pc_write, pc_source=10, instr_done. Next state FETCH.
- pc_source (2 bits, not shown in Ports) is internal to this spec; expose it as output pc_source 2 bits (00 ALU, 01 ALUOut, 10 jump target). It is 00 in all other states.
- Cycle counts:
  - lw: 5
  - sw, R-type, I-type: 4
  - beq/bne, j: 3
  - unknown opcode (feature off): 2
- Outputs not listed in a state are 0, except alu_ctl, which defaults to ADD.
- Opcode/funct are sampled only in DECODE/EXEC/BRANCH. Input changes in FETCH are ignored.
- Unused state encodings go to FETCH on the next edge.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN
- Defined: an unknown opcode in DECODE goes to HALT. HALT asserts illegal, holds all strobes at 0, and stays until rst.
- Undefined: an unknown opcode returns to FETCH as a NOP, and illegal is tied to 0.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode/funct localparams (OP_RTYPE, OP_LW, ...)
  - ALU_AND..ALU_NOR codes
  - ALU-source and pc_source codes
  - state encodings
  - the ALU wrapper must import the same ALU_* codes
- One natural sub-module: alu_ctl_dec (combinational funct/opcode -> alu_ctl, off), reused in R_EXEC and I_EXEC.

Test Plan:
- Reset:
  - rst=1 for 3 cycles -> all outputs 0.
  - After release: cycle 1 shows mem_read=ir_write=pc_write=1, src_b=01, alu_ctl=0010.
- lw:
  - opcode=0x23 -> states FETCH, DECODE, MEM_ADDR (ls=1, src_b=10), MEM_RD (iord=1, mem_read), MEM_WB (reg_write, mem_to_reg=1).
  - instr_done in cycle 5.
- R-type sweep: opcode=0, funct in {0x20, 0x22, 0x24, 0x25, 0x27, 0x2A, 0x00} -> R_EXEC alu_ctl in {0010, 0110, 0000, 0001, 1100, 0111, 0010} respectively, then R_WB reg_dst=1.
- Branch/jump:
  - bne 0x05 -> cycle 3: pc_write_cond=1, branch_ne=1, alu_ctl=0110.
  - j 0x02 -> cycle 3: pc_write=1, pc_source=10.
- ori 0x0D -> I_EXEC off=1, alu_ctl=0001, then I_WB reg_dst=0. Assert rst during I_EXEC -> no reg_write; FETCH follows release.
- Illegal opcode 0x3F:
  - Feature on: HALT, illegal=1 held for 10 cycles.
  - Feature off: back to FETCH after 2 cycles, illegal=0.
